// File: rtl/sdram_responder_if.sv
// Command, address and byte-mask pins of the SDRAM bus as seen by the responder.
// The bidirectional DQ bus stays a plain inout port on the responder itself.
interface sdram_responder_if;
    logic        SDRAM_CKE;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic [1:0]  SDRAM_BA;
    logic [12:0] SDRAM_A;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;

    modport master (
        output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        output SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH
    );

    modport slave (
        input SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        input SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH
    );
endinterface

// File: rtl/sdram_responder.sv
// Behavioural single-word SDRAM device: bank/row tracking, CAS-latency read pipeline,
// byte-masked writes into a 16-bit backing store, refresh counting and protocol error flags.
module sdram_responder #(
    parameter int MEM_AW = 12
) (
    input  logic             clk_sdram,
    input  logic             nreset,
    sdram_responder_if.slave sdram,
    inout  wire  [15:0]      SDRAM_DQ,
    output logic             mode_valid,
    output logic [1:0]       cas_lat,
    output logic [15:0]      refresh_cnt,
    output logic             err,
    output logic [2:0]       err_code
);
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_REFRESH,
        CMD_LOAD_MODE
    } cmd_e;

    cmd_e              cmd;
    logic [3:0]        bank_open;
    logic [12:0]       open_row [4];
    logic [15:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] word_addr;
    logic              access_ok;
    logic              write_en;
    logic              s1_valid;
    logic              s2_valid;
    logic [15:0]       s1_data;
    logic [15:0]       s2_data;
    logic              dq_oe;
    logic [15:0]       dq_out;

    assign SDRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    always_comb begin
        cmd = CMD_NONE;
        if (sdram.SDRAM_CKE && !sdram.SDRAM_nCS) begin
            case ({sdram.SDRAM_nRAS, sdram.SDRAM_nCAS, sdram.SDRAM_nWE})
                3'b011:  cmd = CMD_ACTIVE;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRECHARGE;
                3'b001:  cmd = CMD_REFRESH;
                3'b000:  cmd = CMD_LOAD_MODE;
                default: cmd = CMD_NONE;
            endcase
        end
    end

    assign word_addr = MEM_AW'({sdram.SDRAM_BA, open_row[sdram.SDRAM_BA], sdram.SDRAM_A[8:0]});
    assign access_ok = mode_valid && bank_open[sdram.SDRAM_BA];
    // A write that collides with our own read data on DQ is dropped.
    assign write_en  = (cmd == CMD_WRITE) && access_ok && !dq_oe;

    always_ff @(posedge clk_sdram) begin
        if (write_en) begin
            if (!sdram.SDRAM_DQML) mem[word_addr][7:0]  <= SDRAM_DQ[7:0];
            if (!sdram.SDRAM_DQMH) mem[word_addr][15:8] <= SDRAM_DQ[15:8];
        end
    end

    // Reads land in s2 (CL=3) or s1 (CL=2) and shift toward the DQ driver, so the
    // slot is fixed at issue time and later mode changes do not move it.
    always_ff @(posedge clk_sdram or negedge nreset) begin
        if (!nreset) begin
            bank_open   <= '0;
            for (int i = 0; i < 4; i++) open_row[i] <= '0;
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_data     <= '0;
            s2_data     <= '0;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
            mode_valid  <= 1'b0;
            cas_lat     <= 2'd3;
            refresh_cnt <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            dq_oe    <= s1_valid;
            dq_out   <= s1_data;
            s1_valid <= s2_valid;
            s1_data  <= s2_data;
            s2_valid <= 1'b0;
            case (cmd)
                CMD_ACTIVE: begin
                    if (bank_open[sdram.SDRAM_BA]) begin
                        err      <= 1'b1;
                        err_code <= 3'd2;
                    end
                    bank_open[sdram.SDRAM_BA] <= 1'b1;
                    open_row[sdram.SDRAM_BA]  <= sdram.SDRAM_A;
                end
                CMD_READ: begin
                    if (!access_ok) begin
                        err      <= 1'b1;
                        err_code <= 3'd1;
                    end else if (cas_lat == 2'd2) begin
                        s1_valid <= 1'b1;
                        s1_data  <= mem[word_addr];
                    end else begin
                        s2_valid <= 1'b1;
                        s2_data  <= mem[word_addr];
                    end
                end
                CMD_WRITE: begin
                    if (!access_ok) begin
                        err      <= 1'b1;
                        err_code <= 3'd1;
                    end else if (dq_oe) begin
                        err      <= 1'b1;
                        err_code <= 3'd5;
                    end
                end
                CMD_PRECHARGE: begin
                    if (sdram.SDRAM_A[10]) bank_open <= '0;
                    else bank_open[sdram.SDRAM_BA] <= 1'b0;
                end
                CMD_REFRESH: begin
                    if (|bank_open) begin
                        err      <= 1'b1;
                        err_code <= 3'd4;
                    end
                    if (refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
                end
                CMD_LOAD_MODE: begin
                    if (|bank_open) begin
                        err      <= 1'b1;
                        err_code <= 3'd4;
                    end else begin
                        mode_valid <= 1'b1;
                        if (sdram.SDRAM_A[6:4] == 3'd2 || sdram.SDRAM_A[6:4] == 3'd3) begin
                            cas_lat <= sdram.SDRAM_A[5:4];
                        end else begin
                            cas_lat  <= 2'd3;
                            err      <= 1'b1;
                            err_code <= 3'd3;
                        end
                        if (sdram.SDRAM_A[2:0] != 3'd0) begin
                            err      <= 1'b1;
                            err_code <= 3'd3;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Directed and randomized check of sdram_responder against a transaction-level model
// that tracks memory words, bank state and the edge at which each read word is due.
module tb_sdram_responder;
    localparam int MEM_AW = 12;
    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_BT  = 4'b0110;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk_sdram = 1'b0;
    logic        nreset;
    logic        tb_oe;
    logic [15:0] tb_dq;
    wire  [15:0] dq_bus;
    logic        mode_valid;
    logic [1:0]  cas_lat;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    always #5 clk_sdram = ~clk_sdram;

    sdram_responder_if bus ();

    // An idle bus floats high, so "not driven" reads as 16'hFFFF; stimulus never stores an FF byte.
    assign dq_bus = tb_oe ? tb_dq : 16'hzzzz;
    pullup (dq_bus);

    sdram_responder #(.MEM_AW(MEM_AW)) dut (
        .clk_sdram   (clk_sdram),
        .nreset      (nreset),
        .sdram       (bus.slave),
        .SDRAM_DQ    (dq_bus),
        .mode_valid  (mode_valid),
        .cas_lat     (cas_lat),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    int          tests_run;
    int          tests_failed;
    int          edge_no;
    logic [15:0] ref_mem [int];
    bit          ref_open [4];
    int          ref_row [4];
    bit          ref_mode_valid;
    int          ref_cl;
    bit          ref_err;
    int          ref_code;
    int          ref_refresh;
    logic [15:0] due_data [int];
    bit          due_known [int];
    logic [15:0] last_dq;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) ref_open[i] = 1'b0;
        ref_mode_valid = 1'b0;
        ref_cl         = 3;
        ref_err        = 1'b0;
        ref_code       = 0;
        ref_refresh    = 0;
        due_data.delete();
        due_known.delete();
    endfunction

    function automatic void raise_err(input int code);
        ref_err  = 1'b1;
        ref_code = code;
    endfunction

    function automatic int word_addr(input int ba, input int row, input int col);
        return (ba * (1 << 22) + row * (1 << 9) + col % 512) % (1 << MEM_AW);
    endfunction

    function automatic void model_edge(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                                       input logic [15:0] data, input logic ml, input logic mh, input logic cke);
        int          addr;
        bit          driving;
        bit          any_open;
        logic [15:0] word;
        edge_no++;
        driving = due_data.exists(edge_no);
        if (driving) begin
            due_data.delete(edge_no);
            due_known.delete(edge_no);
        end
        any_open = ref_open[0] | ref_open[1] | ref_open[2] | ref_open[3];
        if (cke && !c[3]) begin
            case (c)
                C_ACT: begin
                    if (ref_open[ba]) raise_err(2);
                    ref_open[ba] = 1'b1;
                    ref_row[ba]  = int'(a);
                end
                C_RD, C_WR: begin
                    addr = word_addr(int'(ba), ref_row[ba], int'(a));
                    if (!ref_mode_valid || !ref_open[ba]) raise_err(1);
                    else if (c == C_WR && driving) raise_err(5);
                    else if (c == C_WR) begin
                        word = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
                        if (!ml) word[7:0]  = data[7:0];
                        if (!mh) word[15:8] = data[15:8];
                        ref_mem[addr] = word;
                    end else begin
                        due_known[edge_no + ref_cl] = ref_mem.exists(addr);
                        due_data[edge_no + ref_cl]  = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
                    end
                end
                C_PRE: begin
                    if (a[10]) for (int i = 0; i < 4; i++) ref_open[i] = 1'b0;
                    else ref_open[ba] = 1'b0;
                end
                C_REF: begin
                    if (any_open) raise_err(4);
                    if (ref_refresh < 65535) ref_refresh++;
                end
                C_LMR: begin
                    if (any_open) raise_err(4);
                    else begin
                        ref_mode_valid = 1'b1;
                        if (a[6:4] == 3'd2 || a[6:4] == 3'd3) ref_cl = int'(a[6:4]);
                        else begin
                            ref_cl = 3;
                            raise_err(3);
                        end
                        if (a[2:0] != 3'd0) raise_err(3);
                    end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_state();
        if (due_data.exists(edge_no + 1)) begin
            if (due_known[edge_no + 1]) checkOutput("dq_data", dq_bus, due_data[edge_no + 1]);
        end else begin
            checkOutput("dq_idle", dq_bus, 16'hFFFF);
        end
        checkOutput("mode_valid", mode_valid, ref_mode_valid);
        checkOutput("cas_lat", cas_lat, ref_cl);
        checkOutput("refresh_cnt", refresh_cnt, ref_refresh);
        checkOutput("err", err, ref_err);
        checkOutput("err_code", err_code, ref_code);
    endtask

    // Called just after a falling edge; presents one command for the next rising edge.
    task automatic applyStimulus(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                                 input logic [15:0] data = 16'h0000, input logic ml = 1'b0,
                                 input logic mh = 1'b0, input logic cke = 1'b1);
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
        bus.SDRAM_CKE  = cke;
        bus.SDRAM_BA   = ba;
        bus.SDRAM_A    = a;
        bus.SDRAM_DQML = ml;
        bus.SDRAM_DQMH = mh;
        tb_dq = data;
        tb_oe = (c == C_WR) && !due_data.exists(edge_no + 1) && !due_data.exists(edge_no + 2);
        @(posedge clk_sdram);
        model_edge(c, ba, a, data, ml, mh, cke);
        @(negedge clk_sdram);
        tb_oe = 1'b0;
        #1;
        last_dq = dq_bus;
        check_state();
    endtask

    task automatic pulse_reset(input int cycles);
        nreset = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_dq_released", dq_bus, 16'hFFFF);
        checkOutput("rst_mode_valid", mode_valid, 1'b0);
        repeat (cycles) @(posedge clk_sdram);
        @(negedge clk_sdram);
        #1;
        check_state();
        nreset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] words [4];
        logic [3:0]  c;
        logic [1:0]  ba;
        logic [12:0] row;
        logic [12:0] col;
        logic [15:0] data;
        int          pick;

        tests_run    = 0;
        tests_failed = 0;
        edge_no      = 0;
        tb_oe        = 1'b0;
        tb_dq        = '0;
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;
        bus.SDRAM_CKE  = 1'b1;
        bus.SDRAM_BA   = '0;
        bus.SDRAM_A    = '0;
        bus.SDRAM_DQML = 1'b0;
        bus.SDRAM_DQMH = 1'b0;
        pulse_reset(3);
        checkOutput("reset_cas_lat", cas_lat, 2'd3);
        checkOutput("reset_refresh_cnt", refresh_cnt, 16'd0);
        checkOutput("reset_err", err, 1'b0);
        checkOutput("reset_err_code", err_code, 3'd0);

        // Basic CL=3 write/read, then a low-byte-masked overwrite.
        applyStimulus(C_LMR, 2'd0, 13'h0230);
        applyStimulus(C_ACT, 2'd1, 13'd5);
        applyStimulus(C_WR, 2'd1, 13'd3, 16'hA55A, 1'b0, 1'b0);
        applyStimulus(C_RD, 2'd1, 13'd3);
        checkOutput("cl3_not_yet_e0", last_dq, 16'hFFFF);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("cl3_not_yet_e1", last_dq, 16'hFFFF);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("cl3_read_data", last_dq, 16'hA55A);
        checkOutput("cl3_cas_lat", cas_lat, 2'd3);
        checkOutput("cl3_no_err", err, 1'b0);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("cl3_released", last_dq, 16'hFFFF);
        applyStimulus(C_WR, 2'd1, 13'd3, 16'h1234, 1'b1, 1'b0);
        applyStimulus(C_RD, 2'd1, 13'd3);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("masked_write", last_dq, 16'h125A);
        applyStimulus(C_NOP, 2'd0, 13'd0);

        // CL=2 back-to-back reads, then a write that collides with read data.
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        applyStimulus(C_PRE, 2'd0, 13'h0400);
        applyStimulus(C_LMR, 2'd0, 13'h0020);
        applyStimulus(C_ACT, 2'd0, 13'd1);
        for (int i = 0; i < 4; i++) applyStimulus(C_WR, 2'd0, 13'(i), words[i]);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(C_RD, 2'd0, 13'(i));
            if (i == 0) checkOutput("burst_before", last_dq, 16'hFFFF);
            else checkOutput("burst_word", last_dq, words[i-1]);
        end
        applyStimulus(C_WR, 2'd0, 13'd0, 16'h0101);
        checkOutput("burst_last_word", last_dq, words[3]);
        checkOutput("write_while_driving", err_code, 3'd5);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("burst_after", last_dq, 16'hFFFF);
        applyStimulus(C_RD, 2'd0, 13'd0);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("dropped_write", last_dq, 16'h1111);
        applyStimulus(C_NOP, 2'd0, 13'd0);

        // Closed-bank read and double activate.
        applyStimulus(C_PRE, 2'd0, 13'h0400);
        applyStimulus(C_RD, 2'd2, 13'd0);
        checkOutput("closed_bank_err", err, 1'b1);
        checkOutput("closed_bank_code", err_code, 3'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(C_NOP, 2'd0, 13'd0);
            checkOutput("closed_bank_no_drive", last_dq, 16'hFFFF);
        end
        applyStimulus(C_ACT, 2'd0, 13'd0);
        applyStimulus(C_ACT, 2'd0, 13'd1);
        checkOutput("double_active_code", err_code, 3'd2);

        // Refresh counting with banks closed and with a bank open.
        pulse_reset(2);
        for (int i = 0; i < 3; i++) applyStimulus(C_REF, 2'd0, 13'd0);
        checkOutput("refresh_three", refresh_cnt, 16'd3);
        checkOutput("refresh_no_err", err, 1'b0);
        applyStimulus(C_ACT, 2'd0, 13'd0);
        applyStimulus(C_REF, 2'd0, 13'd0);
        checkOutput("refresh_open_cnt", refresh_cnt, 16'd4);
        checkOutput("refresh_open_code", err_code, 3'd4);

        // Reset while a CL=3 read is in flight.
        applyStimulus(C_PRE, 2'd0, 13'h0400);
        applyStimulus(C_LMR, 2'd0, 13'h0230);
        applyStimulus(C_ACT, 2'd1, 13'd5);
        applyStimulus(C_RD, 2'd1, 13'd3);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        pulse_reset(2);
        applyStimulus(C_LMR, 2'd0, 13'h0230);
        applyStimulus(C_ACT, 2'd1, 13'd5);
        applyStimulus(C_RD, 2'd1, 13'd3);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        applyStimulus(C_NOP, 2'd0, 13'd0);
        checkOutput("data_survives_reset", last_dq, 16'h125A);
        applyStimulus(C_NOP, 2'd0, 13'd0);

        // Seed every location the random phase can reach.
        applyStimulus(C_PRE, 2'd0, 13'h0400);
        applyStimulus(C_LMR, 2'd0, ($urandom_range(0, 1) != 0) ? 13'h0020 : 13'h0030);
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 2; r++) begin
                applyStimulus(C_ACT, 2'(b), 13'(r));
                for (int k = 0; k < 4; k++)
                    applyStimulus(C_WR, 2'(b), 13'(k), {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))});
                applyStimulus(C_PRE, 2'(b), 13'd0);
            end
        end

        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 99);
            ba   = 2'($urandom_range(0, 3));
            row  = 13'($urandom_range(0, 1));
            if ($urandom_range(0, 1) != 0) row[12] = 1'b1;
            col  = {4'($urandom_range(0, 15)), 9'($urandom_range(0, 3))};
            data = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 254))};
            if (pick < 10) begin
                case ($urandom_range(0, 2))
                    0:       c = C_NOP;
                    1:       c = C_BT;
                    default: c = C_INH;
                endcase
                applyStimulus(c, ba, col);
            end else if (pick < 14) begin
                applyStimulus(($urandom_range(0, 1) != 0) ? C_RD : C_ACT, ba, row, 16'h0000, 1'b0, 1'b0, 1'b0);
            end else if (pick < 30) begin
                applyStimulus(C_ACT, ba, row);
            end else if (pick < 55) begin
                applyStimulus(C_RD, ba, col);
            end else if (pick < 75) begin
                if (due_data.exists(edge_no + 2) && !due_data.exists(edge_no + 1))
                    applyStimulus(C_NOP, ba, col);
                else
                    applyStimulus(C_WR, ba, col, data, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (pick < 88) begin
                applyStimulus(C_PRE, ba, ($urandom_range(0, 1) != 0) ? 13'h0400 : 13'h0000);
            end else if (pick < 94) begin
                applyStimulus(C_REF, ba, col);
            end else if (pick < 97) begin
                applyStimulus(C_LMR, ba, ($urandom_range(0, 1) != 0) ? 13'h0020 : 13'h0030);
            end else begin
                applyStimulus(C_LMR, ba, 13'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
